irq_priority_encoder: RTL and testbench

- 8-to-3 priority encoder with latched request capture and a valid/ack handshake; the encode direction matching the existing 3-to-8 decoder.
- Collects rising edges on eight request lines into a pending register.
- Presents the highest-index eligible pending request as a 3-bit code to the CPU control path.
- Holds that code stable until acknowledged.

---
 rtl/irq_enc_pkg.sv | 18 +
 rtl/prio_enc_8to3.sv | 26 ++
 rtl/irq_priority_encoder.sv | 117 +++++++++++
 tb/tb_irq_priority_encoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_enc_pkg.sv
// Shared constants, FSM state type and helpers for the IRQ priority encoder.
package irq_enc_pkg;

   localparam int CODE_W_DEF = 3;
   localparam int N_REQ_DEF  = 2 ** CODE_W_DEF;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_e;

   // One-hot decode of a request index, the inverse of the encoder.
   function automatic logic [N_REQ_DEF-1:0] onehot(input logic [CODE_W_DEF-1:0] code);
      onehot       = '0;
      onehot[code] = 1'b1;
   endfunction

endpackage

// File: rtl/prio_enc_8to3.sv
// Combinational priority encoder: reports the index of the highest set bit.
module prio_enc_8to3
   import irq_enc_pkg::*;
#(
   parameter  int CODE_W = CODE_W_DEF,
   localparam int N_REQ  = 2 ** CODE_W
) (
   input  logic [N_REQ-1:0]  vec,
   output logic [CODE_W-1:0] idx,
   output logic              any
);

   // Scan upward so the last (highest) set bit overwrites lower ones.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (vec[i]) begin
            idx = CODE_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_priority_encoder.sv
// Interrupt request priority encoder with edge capture and valid/ack handshake.
// Optional request masking is built when IRQ_MASK_EN is defined.
module irq_priority_encoder
   import irq_enc_pkg::*;
#(
   parameter  int CODE_W = CODE_W_DEF,
   localparam int N_REQ  = 2 ** CODE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Enable,
   input  logic [N_REQ-1:0]  Req,
   input  logic              Ack,
`ifdef IRQ_MASK_EN
   input  logic              Mask_we,
   input  logic [N_REQ-1:0]  Mask_in,
`endif
   output logic [CODE_W-1:0] Code,
   output logic              Valid,
   output logic [N_REQ-1:0]  Pending
);

   state_e             state_q, state_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic               valid_q, valid_d;
   logic [N_REQ-1:0]   pending_q, pending_d;
   logic [N_REQ-1:0]   req_q;
   logic               armed_q;
   logic [N_REQ-1:0]   mask_vec;
   logic [N_REQ-1:0]   eligible;
   logic [N_REQ-1:0]   rise;
   logic [N_REQ-1:0]   clr;
   logic [CODE_W-1:0]  top_idx;
   logic               top_any;

`ifdef IRQ_MASK_EN
   // Mask register; a write only affects selection from the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       mask_vec <= '1;
      else if (Mask_we) mask_vec <= Mask_in;
   end
`else
   assign mask_vec = '1;
`endif

   assign eligible = pending_q & mask_vec;

   // armed_q is clear for the first edge after reset so lines already high at
   // release are taken as the resting level, not as a fresh request.
   assign rise = armed_q ? (Req & ~req_q) : '0;

   prio_enc_8to3 #(.CODE_W(CODE_W)) u_prio (
      .vec (eligible),
      .idx (top_idx),
      .any (top_any)
   );

   // Next-state, handshake and pending-clear decode.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      valid_d = valid_q;
      clr     = '0;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (Enable && top_any) begin
               code_d  = top_idx;
               valid_d = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            // Enable low withdraws the grant and outranks a simultaneous Ack.
            if (!Enable) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (Ack) begin
               clr     = N_REQ'(onehot(CODE_W_DEF'(code_q)));
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
      // Set wins: a new rise on the bit being cleared keeps it pending.
      pending_d = (pending_q & ~clr) | rise;
   end

   // State, handshake, capture and pending registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         code_q    <= '0;
         valid_q   <= 1'b0;
         pending_q <= '0;
         req_q     <= '0;
         armed_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q   <= state_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         pending_q <= pending_d;
         req_q     <= Req;
         armed_q   <= 1'b1;
      end
   end

   assign Code    = code_q;
   assign Valid   = valid_q;
   assign Pending = pending_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Self-checking bench for irq_priority_encoder: directed steps plus random
// traffic, compared against a behavioural model every clock.
module tb_irq_priority_encoder;

   localparam int CW = 3;
   localparam int NR = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          Enable = 1'b0;
   logic [NR-1:0] Req = '0;
   logic          Ack = 1'b0;
   logic [CW-1:0] Code;
   logic          Valid;
   logic [NR-1:0] Pending;
`ifdef IRQ_MASK_EN
   logic          Mask_we = 1'b0;
   logic [NR-1:0] Mask_in = '1;
`endif

   int checks = 0;
   int failures = 0;

   // Behavioural model state.
   logic [NR-1:0] m_pend;
   logic [NR-1:0] m_prev;
   logic [NR-1:0] m_mask;
   bit            m_armed;
   bit            m_valid;
   int            m_code;

   irq_priority_encoder dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .Enable  (Enable),
      .Req     (Req),
      .Ack     (Ack),
`ifdef IRQ_MASK_EN
      .Mask_we (Mask_we),
      .Mask_in (Mask_in),
`endif
      .Code    (Code),
      .Valid   (Valid),
      .Pending (Pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int highest(input logic [NR-1:0] v);
      for (int i = NR - 1; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_pend  = '0;
      m_prev  = '0;
      m_mask  = '1;
      m_armed = 0;
      m_valid = 0;
      m_code  = 0;
   endtask

   // One clock of the specified behaviour, using the inputs present at the edge.
   task automatic model_step();
      logic [NR-1:0] elig, clr, rise;
      elig = m_pend & m_mask;
      clr  = '0;
      if (m_valid) begin
         if (!Enable) m_valid = 0;
         else if (Ack) begin
            clr     = NR'(1) << m_code;
            m_valid = 0;
         end
      end else if (Enable && elig != 0) begin
         m_code  = highest(elig);
         m_valid = 1;
      end
      rise    = m_armed ? (Req & ~m_prev) : '0;
      m_pend  = (m_pend & ~clr) | rise;
      m_prev  = Req;
      m_armed = 1;
`ifdef IRQ_MASK_EN
      if (Mask_we) m_mask = Mask_in;
`endif
   endtask

   // Advance one clock, update the model and compare all outputs after the edge.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      check("model_valid", 32'(Valid), 32'(m_valid));
      check("model_pending", 32'(Pending), 32'(m_pend));
      if (m_valid) check("model_code", 32'(Code), 32'(m_code));
   endtask

   initial begin
      model_reset();

      // Reset held with all request lines high.
      Req = 8'hFF;
      tick(); tick();
      check("rst_valid", 32'(Valid), 32'd0);
      check("rst_code", 32'(Code), 32'd0);
      check("rst_pending", 32'(Pending), 32'd0);
      rst_n = 1'b1;
      tick(); tick();
      check("release_no_edge", 32'(Pending), 32'h00);

      // Single request on bit 5.
      Enable = 1'b1;
      Req = 8'h00; tick();
      Req = 8'h20; tick();
      check("single_pending", 32'(Pending), 32'h20);
      check("single_latency", 32'(Valid), 32'd0);
      tick();
      check("single_valid", 32'(Valid), 32'd1);
      check("single_code", 32'(Code), 32'd5);
      Ack = 1'b1; tick(); Ack = 1'b0;
      check("single_ack_pend", 32'(Pending), 32'h00);
      check("single_ack_valid", 32'(Valid), 32'd0);

      // Priority and freeze while presented.
      Req = 8'h00; tick();
      Req = 8'h05; tick(); tick();
      check("prio_code2", 32'(Code), 32'd2);
      Req = 8'h85; tick(); tick();
      check("freeze_code", 32'(Code), 32'd2);
      check("freeze_pend", 32'(Pending), 32'h85);
      Ack = 1'b1; tick(); Ack = 1'b0;
      check("gap_valid", 32'(Valid), 32'd0);
      tick();
      check("next_code7", 32'(Code), 32'd7);
      Ack = 1'b1; tick(); Ack = 1'b0;
      tick();
      check("next_code0", 32'(Code), 32'd0);
      Ack = 1'b1; tick(); Ack = 1'b0;
      check("prio_drained", 32'(Pending), 32'h00);
      Req = 8'h00; tick();

      // Enable low suppresses presentation; stray Ack is ignored.
      Enable = 1'b0;
      Req = 8'h08; tick(); tick();
      check("dis_valid", 32'(Valid), 32'd0);
      check("dis_pend", 32'(Pending), 32'h08);
      Ack = 1'b1; tick(); Ack = 1'b0;
      check("stray_ack_pend", 32'(Pending), 32'h08);
      Enable = 1'b1; tick(); tick();
      check("en_valid", 32'(Valid), 32'd1);
      check("en_code3", 32'(Code), 32'd3);

      // Enable dropped while presented: grant withdrawn, bit retained.
      Enable = 1'b0; Ack = 1'b1; tick(); Ack = 1'b0;
      check("drop_valid", 32'(Valid), 32'd0);
      check("drop_pend", 32'(Pending), 32'h08);
      Enable = 1'b1; tick();
      Ack = 1'b1; tick(); Ack = 1'b0;
      Req = 8'h00; tick();

      // Set wins over clear when bit 4 re-rises in the Ack cycle.
      Req = 8'h10; tick(); tick();
      check("coll_code4", 32'(Code), 32'd4);
      Req = 8'h00; tick();
      Req = 8'h10; Ack = 1'b1; tick(); Ack = 1'b0;
      check("coll_pend", 32'(Pending), 32'h10);
      tick();
      check("coll_regrant", 32'(Code), 32'd4);
      check("coll_regrant_v", 32'(Valid), 32'd1);

      // Asynchronous reset while presenting.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_valid", 32'(Valid), 32'd0);
      check("async_pend", 32'(Pending), 32'h00);
      model_reset();
      Req = 8'h00;
      tick();
      rst_n = 1'b1;
      tick();

`ifdef IRQ_MASK_EN
      Mask_in = 8'h7F; Mask_we = 1'b1; tick(); Mask_we = 1'b0;
      Req = 8'h81; tick(); tick();
      check("mask_code0", 32'(Code), 32'd0);
      Ack = 1'b1; tick(); Ack = 1'b0;
      tick();
      check("mask_hold", 32'(Valid), 32'd0);
      check("mask_pend", 32'(Pending), 32'h80);
      Mask_in = 8'hFF; Mask_we = 1'b1; tick(); Mask_we = 1'b0;
      tick();
      check("unmask_code7", 32'(Code), 32'd7);
      Ack = 1'b1; tick(); Ack = 1'b0;
      Req = 8'h00; tick();
`endif

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         Req    = Req ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
         Enable = ($urandom_range(0, 7) != 0);
         Ack    = $urandom_range(0, 1) == 1;
`ifdef IRQ_MASK_EN
         Mask_we = ($urandom_range(0, 15) == 0);
         Mask_in = 8'($urandom_range(0, 255));
`endif
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
